// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/pause/stop, optional auto-reload and a one-cycle terminal-count pulse
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
    state_e state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic done_q, done_d, expired_q, expired_d;
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        if (stop) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (load) begin
                count_d   = load_val;
                reload_d  = load_val;
                expired_d = 1'b0;
            end else if (start) begin
                state_d   = (count_q != '0) ? RUN : IDLE;
                done_d    = (count_q == '0);
                expired_d = (count_q == '0);
            end
        end else if (state_q == HOLD) begin
            state_d = pause ? HOLD : RUN;
        end else if (pause) begin
            state_d = HOLD;
        end else if (tick) begin
            // count is never 0 in RUN, so anything not above 1 is the expiry tick
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                done_d    = 1'b1;
                expired_d = 1'b1;
                count_d   = auto_reload ? reload_q : '0;
                state_d   = auto_reload ? RUN : IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end
    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboarded random and directed stimulus against a behavioural timer model
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, tick = 1'b0, auto_reload = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] count;
    logic       busy, done, expired;

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       expired;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // model: "running" means a countdown is in progress, "held" means it is paused
    int   m_count = 0, m_reload = 0;
    bit   m_running = 0, m_held = 0, m_expired = 0, m_done = 0;

    countdown_timer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .pause(pause), .tick(tick), .auto_reload(auto_reload),
        .count(count), .busy(busy), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (count !== e.count || busy !== e.busy || done !== e.done || expired !== e.expired) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got count=%0d busy=%b done=%b expired=%b, want count=%0d busy=%b done=%b expired=%b",
                         $time, count, busy, done, expired, e.count, e.busy, e.done, e.expired);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_running = 0; m_held = 0; m_expired = 0; m_done = 0;
    endtask

    task automatic drive(input bit st, input bit ld, input int lv, input bit sa,
                         input bit pa, input bit ti, input bit ar);
        exp_t e;
        @(negedge clk);
        stop = st; load = ld; load_val = lv[7:0]; start = sa; pause = pa; tick = ti; auto_reload = ar;
        m_done = 0;
        if (st) begin
            m_running = 0;
            m_held    = 0;
        end else if (!m_running) begin
            if (ld) begin
                m_count = lv; m_reload = lv; m_expired = 0;
            end else if (sa) begin
                if (m_count == 0) begin
                    m_done = 1; m_expired = 1;
                end else begin
                    m_running = 1; m_expired = 0;
                end
            end
        end else if (m_held) begin
            m_held = pa;
        end else if (pa) begin
            m_held = 1;
        end else if (ti) begin
            if (m_count == 1) begin
                m_done = 1; m_expired = 1;
                m_count = ar ? m_reload : 0;
                m_running = ar;
            end else begin
                m_count = m_count - 1;
            end
        end
        e.count = m_count[7:0]; e.busy = m_running; e.done = m_done; e.expired = m_expired;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input bit ar);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, ar);
    endtask

    // asserts rst between edges and checks the outputs clear without a clock edge
    task automatic async_reset();
        @(posedge clk);
        #3;
        stop = 0; load = 0; start = 0; pause = 0; tick = 0; auto_reload = 0;
        rst = 1'b0;
        #1;
        chk("async_reset count", count, 0);
        chk("async_reset busy", busy, 0);
        chk("async_reset expired", expired, 0);
        chk("async_reset done", done, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2;
        chk("reset count", count, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset expired", expired, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        // zero-count start
        drive(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // one-shot of 5
        drive(0, 1, 5, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        ticks(7, 0);
        idle(2);
        // auto-reload of 3
        drive(0, 1, 3, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        ticks(10, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        idle(2);
        // pause with tick high
        drive(0, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        ticks(2, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 1, 0);
        ticks(4, 0);
        idle(2);
        // stop beats load, then load accepted
        drive(0, 1, 6, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        ticks(2, 0);
        drive(1, 1, 9, 0, 0, 1, 0);
        drive(0, 1, 9, 0, 0, 0, 0);
        idle(1);
        // stop coincident with expiry
        drive(0, 1, 2, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        ticks(1, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        // asynchronous reset mid-run, then zero start
        drive(0, 1, 8, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        ticks(3, 0);
        async_reset();
        drive(0, 0, 0, 1, 0, 0, 0);
        idle(3);
        // full-range count
        drive(0, 1, 255, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        ticks(256, 0);
        // single-count auto-reload fires every tick
        drive(0, 1, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        ticks(4, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            int lv;
            lv = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6));
            drive($urandom_range(99) < 3, $urandom_range(99) < 8, lv, $urandom_range(99) < 15,
                  $urandom_range(99) < 15, $urandom_range(99) < 70, $urandom_range(99) < 50);
            if (i == 1500) async_reset();
        end
        idle(1);
        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
